// File: rtl/rca_pkg.sv
// Shared constants and sizing helpers for the pipelined ripple-carry adder.
package rca_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    function automatic bit rca_cfg_ok(input int width, input int chunk);
        return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

    // Falls back to 1 on a bad configuration so elaboration reaches the fatal check.
    function automatic int rca_stages(input int width, input int chunk);
        return rca_cfg_ok(width, chunk) ? (width / chunk) : 1;
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple adder; also reports the carry into its MSB
// so the final stage can form signed overflow.
module rca_chunk
    import rca_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic carry;

    always_comb begin
        carry = ci;
        s     = '0;
        c_msb = ci;
        for (int i = 0; i < CHUNK; i++) begin
            c_msb = carry;
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/pipelined_rca.sv
// Ripple-carry adder/subtractor split into WIDTH/CHUNK pipeline stages with
// operand skew, sum deskew and a single global valid/ready advance enable.
module pipelined_rca
    import rca_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] A2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             V
);

    localparam int STAGES = rca_stages(WIDTH, CHUNK);

    if (!rca_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
        $fatal(1, "pipelined_rca: WIDTH=%0d is not a positive multiple of CHUNK=%0d", WIDTH, CHUNK);
    end

    logic             en;
    logic [WIDTH-1:0] b_in;
    logic             c_first;

    logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
    logic [STAGES-1:0][WIDTH-1:0] a_d, b_d, s_d;
    logic [STAGES-1:0]            c_q, v_q, vld_q;
    logic [STAGES-1:0]            c_d, v_d, vld_d;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Subtraction is A1 + ~A2 + 1; cin only matters when adding.
    assign b_in    = sub ? ~A2 : A2;
    assign c_first = sub ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_prev, b_prev, s_prev;
        logic             c_prev;
        logic [CHUNK-1:0] sum;
        logic             co, c_msb;

        if (k == 0) begin : g_first
            assign a_prev   = A1;
            assign b_prev   = b_in;
            assign s_prev   = '0;
            assign c_prev   = c_first;
            assign vld_d[k] = in_valid;
        end else begin : g_next
            assign a_prev   = a_q[k-1];
            assign b_prev   = b_q[k-1];
            assign s_prev   = s_q[k-1];
            assign c_prev   = c_q[k-1];
            assign vld_d[k] = vld_q[k-1];
        end

        rca_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a     (a_prev[k*CHUNK +: CHUNK]),
            .b     (b_prev[k*CHUNK +: CHUNK]),
            .ci    (c_prev),
            .s     (sum),
            .co    (co),
            .c_msb (c_msb)
        );

        // Chunk k gets the fresh sum; completed lower chunks ride along unchanged.
        for (genvar j = 0; j < STAGES; j++) begin : g_lane
            if (j == k) begin : g_new
                assign s_d[k][j*CHUNK +: CHUNK] = sum;
            end else begin : g_pass
                assign s_d[k][j*CHUNK +: CHUNK] = s_prev[j*CHUNK +: CHUNK];
            end
        end

        assign a_d[k] = a_prev;
        assign b_d[k] = b_prev;
        assign c_d[k] = co;
        assign v_d[k] = c_msb ^ co;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            v_q   <= '0;
            vld_q <= '0;
        end else if (en) begin
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            c_q   <= c_d;
            v_q   <= v_d;
            vld_q <= vld_d;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign S         = s_q[STAGES-1];
    assign C         = c_q[STAGES-1];
    assign V         = v_q[STAGES-1];

    // Operand bits already consumed and per-stage V of inner stages are dropped on purpose.
    logic unused_bits;
    assign unused_bits = ^{a_q, b_q, s_q, v_q};

endmodule

// File: tb/tb_pipelined_rca.sv
// Directed-vector and stream bench for pipelined_rca at WIDTH=32, CHUNK=8.
module tb_pipelined_rca;

    typedef struct {
        logic [31:0] a1;
        logic [31:0] a2;
        logic        cin;
        logic        sub;
        logic [31:0] exp_s;
        logic        exp_c;
        logic        exp_v;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a1 = '0;
    logic [31:0] a2 = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] S;
    logic        C;
    logic        V;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[12];

    always #5 clk = ~clk;

    pipelined_rca #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A1        (a1),
        .A2        (a2),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .C         (C),
        .V         (V)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference: {V, C, S} straight from the arithmetic definition.
    function automatic logic [33:0] golden(input logic [31:0] x, input logic [31:0] y,
                                           input logic ci, input logic sb);
        logic [31:0] b;
        logic [32:0] sum;
        logic        v;
        b   = sb ? ~y : y;
        sum = {1'b0, x} + {1'b0, b} + {32'b0, (sb ? 1'b1 : ci)};
        v   = (x[31] == b[31]) && (sum[31] != x[31]);
        return {v, sum};
    endfunction

    task automatic run_vec(input int i);
        int lat;
        @(negedge clk);
        a1 = vecs[i].a1; a2 = vecs[i].a2; cin = vecs[i].cin; sub = vecs[i].sub;
        in_valid = 1'b1;
        #1 check($sformatf("vec%0d_in_ready", i), {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 20);
        check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
        check($sformatf("vec%0d_S", i), {32'b0, S}, {32'b0, vecs[i].exp_s});
        check($sformatf("vec%0d_C", i), {63'b0, C}, {63'b0, vecs[i].exp_c});
        check($sformatf("vec%0d_V", i), {63'b0, V}, {63'b0, vecs[i].exp_v});
        @(posedge clk);
    endtask

    // rnd=0: back-to-back table beats, out_ready low in cycles 6..8.
    // rnd=1: random operands, in_valid gaps and out_ready back-pressure.
    task automatic run_stream(input string tag, input int nbeats, input bit rnd, input int max_cycles);
        logic [33:0] q[$];
        int  sent = 0;
        int  got  = 0;
        int  cyc  = 0;
        bit  holding = 1'b0;
        bit  push, pop;
        while ((sent < nbeats || q.size() != 0) && cyc < max_cycles) begin
            @(negedge clk);
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            else     out_ready = !(cyc >= 6 && cyc <= 8);
            if (!holding) begin
                if (sent < nbeats && (!rnd || $urandom_range(0, 2) != 0)) begin
                    if (rnd) begin
                        a1 = $urandom; a2 = $urandom;
                        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                    end else begin
                        a1 = vecs[sent].a1; a2 = vecs[sent].a2;
                        cin = vecs[sent].cin; sub = vecs[sent].sub;
                    end
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            #1;
            if (!rnd) begin
                if (cyc >= 6 && cyc <= 8) begin
                    check($sformatf("%s_stall_in_ready_c%0d", tag, cyc), {63'b0, in_ready}, 64'd0);
                    check($sformatf("%s_stall_out_valid_c%0d", tag, cyc), {63'b0, out_valid}, 64'd1);
                end else begin
                    check($sformatf("%s_in_ready_c%0d", tag, cyc), {63'b0, in_ready}, 64'd1);
                end
            end
            if (out_valid) begin
                if (q.size() == 0) check($sformatf("%s_spurious_out_c%0d", tag, cyc), 64'd1, 64'd0);
                else check($sformatf("%s_result%0d", tag, got), {30'b0, V, C, S}, {30'b0, q[0]});
            end
            pop  = out_valid && out_ready;
            push = in_valid && in_ready;
            @(posedge clk);
            if (pop && q.size() != 0) begin
                void'(q.pop_front());
                got++;
            end
            if (push) begin
                q.push_back(golden(a1, a2, cin, sub));
                sent++;
            end
            holding = in_valid && !push;
            cyc++;
        end
        check({tag, "_beats_out"}, 64'(got), 64'(nbeats));
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[2]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[3]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[4]  = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0};
        vecs[5]  = '{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0, 1'b0};
        vecs[6]  = '{32'h00000010, 32'h00000010, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[7]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[9]  = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[10] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[11] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_S", {32'b0, S}, 64'd0);
        check("rst_C", {63'b0, C}, 64'd0);
        check("rst_V", {63'b0, V}, 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(i);

        run_stream("stall", 8, 1'b0, 100);
        run_stream("rand", 200, 1'b1, 3000);

        // Three beats in flight, reset lands when the first has reached the output.
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            a1 = vecs[i].a1; a2 = vecs[i].a2; cin = vecs[i].cin; sub = vecs[i].sub;
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_out_valid", {63'b0, out_valid}, 64'd1);
        check("pre_rst_S", {32'b0, S}, {32'b0, vecs[1].exp_s});
        rst = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("mid_rst_S", {32'b0, S}, 64'd0);
        check("mid_rst_C", {63'b0, C}, 64'd0);
        check("mid_rst_V", {63'b0, V}, 64'd0);
        check("mid_rst_in_ready", {63'b0, in_ready}, 64'd1);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        begin
            int stale = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (out_valid) stale++;
            end
            check("post_rst_stale", 64'(stale), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
